// File: rtl/rsa_seq_pkg.sv
// Shared opcodes, FSM state/phase types and operand-to-opcode mapping for the
// rsa_wrapper host sequencer.
package rsa_seq_pkg;

    localparam logic [3:0] CMD_READ_X       = 4'd1;
    localparam logic [3:0] CMD_READ_E       = 4'd3;
    localparam logic [3:0] CMD_READ_M       = 4'd9;
    localparam logic [3:0] CMD_READ_R       = 4'd5;
    localparam logic [3:0] CMD_READ_R2      = 4'd7;
    localparam logic [3:0] CMD_WRITE_RESULT = 4'd2;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StCmd,
        StGap,
        StData,
        StWaitD,
        StAck,
        StGap2,
        StRd,
        StRes
    } seq_state_e;

    // Which part of the transaction the shared CMD/GAP/WAITD/ACK/GAP2 steps belong to.
    typedef enum logic [1:0] {
        PhLoad,
        PhComp,
        PhRead
    } seq_phase_e;

    // A reuse job only ever sends X, whatever the index counter holds.
    function automatic logic [3:0] op_opcode(input int unsigned idx, input logic reuse);
        logic [3:0] op;
        op = CMD_READ_R2;
        if (reuse) begin
            op = CMD_READ_X;
        end else begin
            case (idx)
                0:       op = CMD_READ_X;
                1:       op = CMD_READ_E;
                2:       op = CMD_READ_M;
                3:       op = CMD_READ_R;
                default: op = CMD_READ_R2;
            endcase
        end
        return op;
    endfunction

    function automatic logic is_wait_state(input seq_state_e st);
        return (st == StData) || (st == StWaitD) || (st == StRd);
    endfunction

endpackage

// File: rtl/rsa_host_sequencer_watchdog.sv
// Wait-state watchdog for rsa_host_sequencer: counts cycles spent in one DATA, WAITD or RD
// visit and flags expiry at 2**TMO_W-1. Only built when RSA_SEQ_TIMEOUT_EN is defined.
module rsa_seq_watchdog
    import rsa_seq_pkg::*;
#(
    parameter int unsigned TMO_W = 20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  seq_state_e state_i,
    output logic       expired_o
);

    localparam logic [TMO_W-1:0] CntMax = '1;
    localparam logic [TMO_W-1:0] CntOne = TMO_W'(1);

    logic [TMO_W-1:0] cnt_q;
    seq_state_e       state_prev_q;
    logic             waiting;

    assign waiting = is_wait_state(state_i);

    // cnt_q holds the number of completed cycles in the current state visit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            state_prev_q <= StIdle;
        end else begin
            state_prev_q <= state_i;
            if (state_i != state_prev_q) begin
                cnt_q <= waiting ? CntOne : '0;
            end else if (waiting && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CntOne;
            end
        end
    end

    assign expired_o = waiting && (cnt_q == CntMax);

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host-side master for the rsa_wrapper command/data interface: loads operands, issues
// compute and read-back, returns the result. RSA_SEQ_TIMEOUT_EN enables a wait watchdog.
module rsa_host_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 1024,
    parameter int unsigned CMD_W   = 32,
    parameter int unsigned T_W     = 10,
    parameter int unsigned NUM_OPS = 5
`ifdef RSA_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W   = 20
`endif
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [T_W-1:0]    job_t_i,
    input  logic              job_reuse_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [DATA_W-1:0] op_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_err_o,
    output logic [CMD_W-1:0]  arm_to_fpga_cmd_o,
    output logic              arm_to_fpga_cmd_valid_o,
    input  logic              arm_to_fpga_done_i,
    output logic              arm_to_fpga_done_read_o,
    output logic [DATA_W-1:0] arm_to_fpga_data_o,
    output logic              arm_to_fpga_data_valid_o,
    input  logic              arm_to_fpga_data_ready_i,
    input  logic [DATA_W-1:0] fpga_to_arm_data_i,
    input  logic              fpga_to_arm_data_valid_i,
    output logic              fpga_to_arm_data_ready_o
);

    localparam int unsigned    K_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [K_W-1:0] KLast = K_W'(NUM_OPS - 1);
    localparam logic [K_W-1:0] KOne  = K_W'(1);

    seq_state_e        state_q;
    seq_phase_e        phase_q;
    logic [K_W-1:0]    k_q;
    logic [T_W-1:0]    t_q;
    logic              reuse_q;

    logic              job_ready_q;
    logic              op_ready_q;
    logic [CMD_W-1:0]  cmd_q;
    logic              cmd_valid_q;
    logic              done_read_q;
    logic [DATA_W-1:0] a2f_data_q;
    logic              a2f_valid_q;
    logic              f2a_ready_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              wd_expired;

`ifdef RSA_SEQ_TIMEOUT_EN
    logic res_err_q;

    rsa_seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .state_i   (state_q),
        .expired_o (wd_expired)
    );

    assign res_err_o = res_err_q;
`else
    assign wd_expired = 1'b0;
    assign res_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            phase_q     <= PhLoad;
            k_q         <= '0;
            t_q         <= '0;
            reuse_q     <= 1'b0;
            job_ready_q <= 1'b0;
            op_ready_q  <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            done_read_q <= 1'b0;
            a2f_data_q  <= '0;
            a2f_valid_q <= 1'b0;
            f2a_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
        end else if (wd_expired) begin
            // Abandon the transaction: release every master handshake and report an error.
            cmd_valid_q <= 1'b0;
            done_read_q <= 1'b0;
            a2f_valid_q <= 1'b0;
            f2a_ready_q <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b1;
`ifdef RSA_SEQ_TIMEOUT_EN
            res_err_q   <= 1'b1;
`endif
            state_q     <= StRes;
        end else begin
            unique case (state_q)
                StIdle: begin
                    job_ready_q <= 1'b1;
                    if (job_valid_i && job_ready_q) begin
                        job_ready_q <= 1'b0;
                        t_q         <= job_t_i;
                        reuse_q     <= job_reuse_i;
                        k_q         <= job_reuse_i ? KLast : '0;
                        phase_q     <= PhLoad;
                        op_ready_q  <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (op_valid_i) begin
                        a2f_data_q  <= op_data_i;
                        op_ready_q  <= 1'b0;
                        cmd_q       <= CMD_W'(op_opcode(32'(k_q), reuse_q));
                        cmd_valid_q <= 1'b1;
                        state_q     <= StCmd;
                    end
                end
                StCmd: begin
                    cmd_valid_q <= 1'b0;
                    state_q     <= StGap;
                end
                StGap: begin
                    unique case (phase_q)
                        PhLoad: begin
                            a2f_valid_q <= 1'b1;
                            state_q     <= StData;
                        end
                        PhComp: state_q <= StWaitD;
                        default: begin
                            f2a_ready_q <= 1'b1;
                            state_q     <= StRd;
                        end
                    endcase
                end
                StData: begin
                    if (arm_to_fpga_data_ready_i) begin
                        a2f_valid_q <= 1'b0;
                        state_q     <= StWaitD;
                    end
                end
                StWaitD: begin
                    if (arm_to_fpga_done_i) begin
                        done_read_q <= 1'b1;
                        state_q     <= StAck;
                    end
                end
                StAck: begin
                    done_read_q <= 1'b0;
                    state_q     <= StGap2;
                end
                StGap2: begin
                    unique case (phase_q)
                        PhLoad: begin
                            if (k_q != KLast) begin
                                k_q        <= k_q + KOne;
                                op_ready_q <= 1'b1;
                                state_q    <= StLoad;
                            end else begin
                                phase_q     <= PhComp;
                                cmd_q       <= {t_q, {(CMD_W - T_W){1'b0}}};
                                cmd_valid_q <= 1'b1;
                                state_q     <= StCmd;
                            end
                        end
                        PhComp: begin
                            phase_q     <= PhRead;
                            cmd_q       <= CMD_W'(CMD_WRITE_RESULT);
                            cmd_valid_q <= 1'b1;
                            state_q     <= StCmd;
                        end
                        default: begin
                            res_valid_q <= 1'b1;
                            state_q     <= StRes;
                        end
                    endcase
                end
                StRd: begin
                    if (fpga_to_arm_data_valid_i) begin
                        res_data_q  <= fpga_to_arm_data_i;
                        f2a_ready_q <= 1'b0;
                        state_q     <= StWaitD;
                    end
                end
                StRes: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
                        res_err_q   <= 1'b0;
`endif
                        job_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign job_ready_o              = job_ready_q;
    assign op_ready_o               = op_ready_q;
    assign res_valid_o              = res_valid_q;
    assign res_data_o               = res_data_q;
    assign arm_to_fpga_cmd_o        = cmd_q;
    assign arm_to_fpga_cmd_valid_o  = cmd_valid_q;
    assign arm_to_fpga_done_read_o  = done_read_q;
    assign arm_to_fpga_data_o       = a2f_data_q;
    assign arm_to_fpga_data_valid_o = a2f_valid_q;
    assign fpga_to_arm_data_ready_o = f2a_ready_q;

endmodule
